// File: rtl/valid_grant_fifo_if.sv
// Valid/grant handshake bundle for valid_grant_fifo: push side (producer) and pop side (consumer).
// A word moves on a rising edge only when its valid and grant are both high in that cycle.
interface valid_grant_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  push_valid_i;
    logic [DATA_WIDTH-1:0] push_data_i;
    logic                  push_grant_o;
    logic                  pop_valid_o;
    logic [DATA_WIDTH-1:0] pop_data_o;
    logic                  pop_grant_i;

    // FIFO side of the bundle
    modport slave (
        input  push_valid_i,
        input  push_data_i,
        input  pop_grant_i,
        output push_grant_o,
        output pop_valid_o,
        output pop_data_o
    );

    // Producer/consumer side of the bundle
    modport master (
        output push_valid_i,
        output push_data_i,
        output pop_grant_i,
        input  push_grant_o,
        input  pop_valid_o,
        input  pop_data_o
    );
endinterface

// File: rtl/valid_grant_fifo.sv
// First-word fall-through FIFO with valid/grant handshakes on both sides, DEPTH entries (any DEPTH >= 2).
// Define FIFO_STATUS_EN to add the level_o / full_o / empty_o status outputs.
module valid_grant_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    valid_grant_fifo_if.slave          bus
`ifdef FIFO_STATUS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_EMPTY = '0;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic push_grant;
    logic pop_valid;
    logic push_fire;
    logic pop_fire;

    // Grant is held low while reset is asserted even though count already reads zero.
    assign push_grant = reset_n & (count != CNT_FULL);
    assign pop_valid  = (count != CNT_EMPTY);
    assign push_fire  = bus.push_valid_i & push_grant;
    assign pop_fire   = bus.pop_grant_i & pop_valid;

    assign bus.push_grant_o = push_grant;
    assign bus.pop_valid_o  = pop_valid;
    assign bus.pop_data_o   = pop_valid ? mem[rd_ptr] : '0;

    // Storage carries no reset; pop_data_o is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= bus.push_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_STATUS_EN
    assign level_o = count;
    assign full_o  = (count == CNT_FULL);
    assign empty_o = (count == CNT_EMPTY);
`endif

endmodule

// File: tb/tb_valid_grant_fifo.sv
// Directed bench for valid_grant_fifo: a queue model tracks stored words and every cycle's outputs are checked.
module tb_valid_grant_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk;
  logic reset_n;

  int compared;
  int mismatched;

  logic [DW-1:0] exp_q[$];

  valid_grant_fifo_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FIFO_STATUS_EN
  logic [CW-1:0] level_o;
  logic          full_o;
  logic          empty_o;
`endif

  valid_grant_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
`ifdef FIFO_STATUS_EN
    ,
    .level_o(level_o),
    .full_o (full_o),
    .empty_o(empty_o)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_push_grant"}, 32'(bus.push_grant_o), 32'd0);
    check({tag, "_pop_valid"},  32'(bus.pop_valid_o),  32'd0);
    check({tag, "_pop_data"},   32'(bus.pop_data_o),   32'd0);
`ifdef FIFO_STATUS_EN
    check({tag, "_level"}, 32'(level_o), 32'd0);
    check({tag, "_full"},  32'(full_o),  32'd0);
    check({tag, "_empty"}, 32'(empty_o), 32'd1);
`endif
  endtask

  // One clock cycle: drive, check outputs against the model, take the edge, update the model.
  task automatic cycle(input logic pv, input logic [DW-1:0] pd, input logic pg);
    int  n;
    logic push_ok;
    logic pop_ok;
    bus.push_valid_i = pv;
    bus.push_data_i  = pd;
    bus.pop_grant_i  = pg;
    #1;
    n = exp_q.size();
    check("push_grant", 32'(bus.push_grant_o), 32'(n != DEPTH));
    check("pop_valid",  32'(bus.pop_valid_o),  32'(n != 0));
    if (n != 0) check("pop_data", 32'(bus.pop_data_o), 32'(exp_q[0]));
    else        check("pop_data_empty", 32'(bus.pop_data_o), 32'd0);
`ifdef FIFO_STATUS_EN
    check("level", 32'(level_o), 32'(n));
    check("full",  32'(full_o),  32'(n == DEPTH));
    check("empty", 32'(empty_o), 32'(n == 0));
`endif
    push_ok = pv && (n != DEPTH);
    pop_ok  = pg && (n != 0);
    @(posedge clk);
    if (pop_ok)  void'(exp_q.pop_front());
    if (push_ok) exp_q.push_back(pd);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    bus.push_valid_i = 1'b0;
    bus.push_data_i  = '0;
    bus.pop_grant_i  = 1'b0;

    // reset held low
    #12;
    check_reset_outputs("in_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("release_push_grant", 32'(bus.push_grant_o), 32'd1);
    check("release_pop_valid",  32'(bus.pop_valid_o),  32'd0);

    // streaming: one word in flight, pushed and popped every cycle
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h03, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // fill with no pops, then an ignored fifth push
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    cycle(1'b1, 8'h14, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // full with simultaneous push/pop: only the pop fires
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    cycle(1'b1, 8'h99, 1'b1);
    cycle(1'b1, 8'hAA, 1'b0);
    // pointer wrap with mixed random data
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);

    // random traffic
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);

    // reset mid-operation with two entries stored
    cycle(1'b1, 8'h61, 1'b0);
    cycle(1'b1, 8'h62, 1'b0);
    bus.push_valid_i = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h55, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
